// File: rtl/spi_reg_pkg.sv
// Shared constants for the SPI register bank: address map, bit positions, sizes.
package spi_reg_pkg;

  localparam int NUM_REGS = 8;
  localparam int NUM_CFG  = 5;
  localparam int CNT_W    = 8;

  localparam int ADDR_CTRL   = 0;
  localparam int ADDR_CFG1   = 1;
  localparam int ADDR_CFG5   = 5;
  localparam int ADDR_WR_CNT = 6;
  localparam int ADDR_ERR    = 7;

  localparam int CTRL_CLR_CNT = 0;
  localparam int CTRL_LOCK    = 1;

  localparam int ERR_RO     = 0;
  localparam int ERR_LOCKED = 1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (ena) begin
      if (clr)                        count_d = '0;
      else if (inc && count_q != '1)  count_d = count_q + W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/spi_reg_bank.sv
// Register bank behind an SPI slave: CTRL, five lockable CFG registers,
// a saturating write counter and sticky W1C error flags.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int REG_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic [ADDR_W-1:0]        reg_addr,
  input  logic [REG_W-1:0]         reg_wdata,
  input  logic                     reg_wdata_dv,
  output logic [REG_W-1:0]         reg_rdata,
  output logic [7:0]               status,
  output logic [NUM_CFG*REG_W-1:0] cfg_o,
  output logic [NUM_CFG-1:0]       cfg_upd
);

  logic [REG_W-1:0]              ctrl_q, ctrl_d;
  logic [NUM_CFG-1:0][REG_W-1:0] cfg_q, cfg_d;
  logic [NUM_CFG-1:0]            cfg_upd_q, cfg_upd_d;
  logic [1:0]                    err_q, err_d, err_set, err_clr;
  logic                          cnt_inc, cnt_clr;
  logic [CNT_W-1:0]              wr_cnt;
  int                            addr_i;

  assign addr_i = int'(reg_addr);

  always_comb begin
    ctrl_d    = ctrl_q;
    cfg_d     = cfg_q;
    cfg_upd_d = '0;
    err_set   = '0;
    err_clr   = '0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    if (ena && reg_wdata_dv) begin
      if (addr_i == ADDR_CTRL) begin
        ctrl_d               = reg_wdata;
        ctrl_d[CTRL_CLR_CNT] = 1'b0;
        cnt_clr              = reg_wdata[CTRL_CLR_CNT];
        cnt_inc              = ~reg_wdata[CTRL_CLR_CNT];
      end else if (addr_i == ADDR_WR_CNT) begin
        err_set[ERR_RO] = 1'b1;
      end else if (addr_i == ADDR_ERR) begin
        err_clr = reg_wdata[ERR_LOCKED:ERR_RO];
        cnt_inc = 1'b1;
      end else begin
        for (int n = 0; n < NUM_CFG; n++) begin
          if (addr_i == ADDR_CFG1 + n) begin
            if (ctrl_q[CTRL_LOCK]) begin
              err_set[ERR_LOCKED] = 1'b1;
            end else begin
              cfg_d[n]     = reg_wdata;
              cfg_upd_d[n] = 1'b1;
              cnt_inc      = 1'b1;
            end
          end
        end
      end
    end
    // Set is applied after the clear so a same-cycle set wins.
    err_d = (err_q & ~err_clr) | err_set;
  end

  // NOTE: each register is reset individually; this is a handful of flops, not a RAM array.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= '0;
      cfg_q     <= '0;
      cfg_upd_q <= '0;
      err_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      cfg_q     <= cfg_d;
      cfg_upd_q <= cfg_upd_d;
      err_q     <= err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_wr_cnt (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .count (wr_cnt)
  );

  always_comb begin
    reg_rdata = '0;
    if (addr_i == ADDR_CTRL)        reg_rdata = ctrl_q;
    else if (addr_i == ADDR_WR_CNT) reg_rdata = REG_W'(wr_cnt);
    else if (addr_i == ADDR_ERR)    reg_rdata = REG_W'(err_q);
    else begin
      for (int n = 0; n < NUM_CFG; n++)
        if (addr_i == ADDR_CFG1 + n) reg_rdata = cfg_q[n];
    end
  end

  assign status  = {4'b0000, ctrl_q[CTRL_LOCK], err_q, |wr_cnt};
  assign cfg_o   = cfg_q;
  assign cfg_upd = cfg_upd_q & {NUM_CFG{ena}};

endmodule
